// File: rtl/screen_refresh_scheduler_if.sv
// Bundled mark / framebuffer / byte-stream signals of the OLED page refresh scheduler.
// master = scheduler side, slave = environment side (mark source, framebuffer RAM, SPI shifter).
interface screen_refresh_scheduler_if;
    logic       mark_valid;
    logic [2:0] mark_page;
    logic       mark_all;
    logic [9:0] fb_addr;
    logic [7:0] fb_data;
    // Byte stream: a byte moves on a clock edge where tx_valid && tx_ready. While
    // tx_valid is high and tx_ready low, tx_byte/tx_dc hold; tx_valid only drops
    // after a transfer (or on reset).
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_dc;
    logic       busy;
    logic [2:0] cur_page;
    logic [1:0] dbg_state;

    modport master (
        input  mark_valid, mark_page, mark_all, fb_data, tx_ready,
        output fb_addr, tx_valid, tx_byte, tx_dc, busy, cur_page, dbg_state
    );

    modport slave (
        output mark_valid, mark_page, mark_all, fb_data, tx_ready,
        input  fb_addr, tx_valid, tx_byte, tx_dc, busy, cur_page, dbg_state
    );
endinterface

// File: rtl/screen_refresh_scheduler.sv
// Round-robin dirty-page refresh scheduler for a 128x64 SSD1306-class OLED.
// Optional macro SCREEN_SCHED_POWERUP_PAINT_EN: reset marks every page dirty.
module screen_refresh_scheduler #(
    parameter int COL_START = 0,
    parameter int NUM_PAGES = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    screen_refresh_scheduler_if.master    bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, FETCH = 2'd2, DATA = 2'd3} state_t;

    localparam logic [7:0] PAGE_MASK = 8'((9'd1 << NUM_PAGES) - 9'd1);
    localparam logic [7:0] COL_FIRST = 8'(COL_START);
    localparam logic [7:0] COL_LAST  = 8'(COL_START + 127);
`ifdef SCREEN_SCHED_POWERUP_PAINT_EN
    localparam logic [7:0] DIRTY_RESET = PAGE_MASK;
`else
    localparam logic [7:0] DIRTY_RESET = 8'd0;
`endif

    state_t     state;
    logic [7:0] dirty;       // bits at and above NUM_PAGES stay zero
    logic [7:0] dirty_set;
    logic [7:0] dirty_clr;
    logic [2:0] rr_ptr;
    logic [2:0] pick;
    logic       pick_found;
    logic [2:0] cmd_idx;
    logic [6:0] col;
    logic       xfer;

    function automatic logic [2:0] wrap_add(input logic [2:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_PAGES) s = s - NUM_PAGES;
        return s[2:0];
    endfunction

    function automatic logic [7:0] cmd_rom(input logic [2:0] idx, input logic [2:0] page);
        case (idx)
            3'd0:    return 8'h21;
            3'd1:    return COL_FIRST;
            3'd2:    return COL_LAST;
            3'd3:    return 8'h22;
            default: return {5'd0, page};
        endcase
    endfunction

    assign xfer          = bus.tx_valid && bus.tx_ready;
    assign bus.dbg_state = state;

    always_comb begin
        dirty_set = 8'd0;
        if (bus.mark_all) dirty_set = PAGE_MASK;
        if (bus.mark_valid && int'(bus.mark_page) < NUM_PAGES) dirty_set[bus.mark_page] = 1'b1;
    end

    // Scan downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        pick       = rr_ptr;
        pick_found = 1'b0;
        for (int i = NUM_PAGES - 1; i >= 0; i--) begin
            if (dirty[wrap_add(rr_ptr, i)]) begin
                pick       = wrap_add(rr_ptr, i);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        dirty_clr = 8'd0;
        if (state == IDLE && pick_found) dirty_clr[pick] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            dirty        <= DIRTY_RESET;
            rr_ptr       <= 3'd0;
            cmd_idx      <= 3'd0;
            col          <= 7'd0;
            bus.tx_valid <= 1'b0;
            bus.tx_byte  <= 8'd0;
            bus.tx_dc    <= 1'b0;
            bus.fb_addr  <= 10'd0;
            bus.busy     <= 1'b0;
            bus.cur_page <= 3'd0;
        end else begin
            // A mark landing on the bit being cleared wins, so the page is served again.
            dirty <= (dirty & ~dirty_clr) | dirty_set;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state        <= CMD;
                        cmd_idx      <= 3'd0;
                        col          <= 7'd0;
                        bus.cur_page <= pick;
                        bus.busy     <= 1'b1;
                        bus.tx_valid <= 1'b1;
                        bus.tx_byte  <= 8'h21;
                        bus.tx_dc    <= 1'b0;
                        bus.fb_addr  <= {pick, 7'd0};
                    end
                end
                CMD: begin
                    if (xfer) begin
                        if (cmd_idx == 3'd5) begin
                            state        <= FETCH;
                            col          <= 7'd0;
                            bus.tx_valid <= 1'b0;
                        end else begin
                            cmd_idx     <= cmd_idx + 3'd1;
                            bus.tx_byte <= cmd_rom(cmd_idx + 3'd1, bus.cur_page);
                        end
                    end
                end
                FETCH: begin
                    // fb_addr already points at col; advance it now so the RAM's
                    // one-cycle latency is hidden behind the DATA cycle.
                    state        <= DATA;
                    bus.tx_valid <= 1'b1;
                    bus.tx_dc    <= 1'b1;
                    bus.tx_byte  <= bus.fb_data;
                    if (col != 7'd127) bus.fb_addr <= {bus.cur_page, col + 7'd1};
                end
                DATA: begin
                    if (xfer) begin
                        bus.tx_valid <= 1'b0;
                        if (col == 7'd127) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                            rr_ptr   <= wrap_add(bus.cur_page, 1);
                        end else begin
                            col   <= col + 7'd1;
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_screen_refresh_scheduler.sv
// Directed bench for screen_refresh_scheduler: default instance plus a COL_START=2 / NUM_PAGES=4 one.
// Expected byte streams come from hand-written command bytes and a framebuffer pattern function.
module tb_screen_refresh_scheduler;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    screen_refresh_scheduler_if bus ();
    screen_refresh_scheduler_if bus2 ();

    screen_refresh_scheduler dut (.clk(clk), .resetn(resetn), .bus(bus));
    screen_refresh_scheduler #(.COL_START(2), .NUM_PAGES(4)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_xfer_cyc = 0;
    int mark_cyc = 0;
    bit stall_mode = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_q2[$];
    logic stall_p = 1'b0;
    logic stall_p2 = 1'b0;
    logic [8:0] held = 9'd0;
    logic [8:0] held2 = 9'd0;

    function automatic logic [7:0] fb_pat(input logic [9:0] a);
        return a[7:0] ^ {a[9:7], 5'b10110};
    endfunction

    // Framebuffer RAM with one-cycle registered read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.fb_data <= fb_pat(bus.fb_addr);
        bus2.fb_data <= fb_pat(bus2.fb_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (stall_p) check("stall_hold", {bus.tx_valid, bus.tx_dc, bus.tx_byte}, {1'b1, held});
            if (bus.tx_valid && bus.tx_ready) begin
                last_xfer_cyc = cyc + 1;
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("tx_stream", {bus.tx_dc, bus.tx_byte}, exp_q.pop_front());
            end
            stall_p = bus.tx_valid && !bus.tx_ready;
            held = {bus.tx_dc, bus.tx_byte};
        end else begin
            stall_p = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (stall_p2) check("stall_hold2", {bus2.tx_valid, bus2.tx_dc, bus2.tx_byte}, {1'b1, held2});
            if (bus2.tx_valid && bus2.tx_ready) begin
                check("byte_expected2", exp_q2.size() != 0, 1);
                if (exp_q2.size() != 0) check("tx_stream2", {bus2.tx_dc, bus2.tx_byte}, exp_q2.pop_front());
            end
            stall_p2 = bus2.tx_valid && !bus2.tx_ready;
            held2 = {bus2.tx_dc, bus2.tx_byte};
        end else begin
            stall_p2 = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (stall_mode) bus.tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_page(input bit second, input int page);
        logic [8:0] e[$];
        e.push_back({1'b0, 8'h21});
        e.push_back({1'b0, second ? 8'h02 : 8'h00});
        e.push_back({1'b0, second ? 8'h81 : 8'h7F});
        e.push_back({1'b0, 8'h22});
        e.push_back({1'b0, 8'(page)});
        e.push_back({1'b0, 8'(page)});
        for (int c = 0; c < 128; c++) e.push_back({1'b1, fb_pat(10'(page * 128 + c))});
        foreach (e[i]) begin
            if (second) exp_q2.push_back(e[i]);
            else exp_q.push_back(e[i]);
        end
    endtask

    task automatic strobe(input bit second, input bit all, input logic [2:0] page);
        if (second) begin
            bus2.mark_valid = !all; bus2.mark_all = all; bus2.mark_page = page;
        end else begin
            bus.mark_valid = !all; bus.mark_all = all; bus.mark_page = page;
        end
        tick();
        bus.mark_valid = 1'b0; bus.mark_all = 1'b0;
        bus2.mark_valid = 1'b0; bus2.mark_all = 1'b0;
        mark_cyc = cyc;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_q2.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", (exp_q.size() == 0) && (exp_q2.size() == 0), 1);
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        bus.mark_valid = 1'b0; bus.mark_page = 3'd0; bus.mark_all = 1'b0; bus.tx_ready = 1'b1;
        bus2.mark_valid = 1'b0; bus2.mark_page = 3'd0; bus2.mark_all = 1'b0; bus2.tx_ready = 1'b1;
        repeat (3) tick();
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_byte", bus.tx_byte, 0);
        check("rst_tx_dc", bus.tx_dc, 0);
        check("rst_fb_addr", bus.fb_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cur_page", bus.cur_page, 0);
        check("rst_state", bus.dbg_state, 0);
        check("rst_tx_valid2", bus2.tx_valid, 0);
`ifdef SCREEN_SCHED_POWERUP_PAINT_EN
        for (int p = 0; p < 8; p++) push_page(1'b0, p);
        for (int p = 0; p < 4; p++) push_page(1'b1, p);
        resetn = 1'b1;
        drain(6000);
`else
        resetn = 1'b1;
        repeat (5) tick();
        check("idle_after_reset", {bus.busy, bus.tx_valid}, 0);
`endif

        // mark_all from rr_ptr=0: pages 0..7 in order
        for (int p = 0; p < 8; p++) push_page(1'b0, p);
        strobe(1'b0, 1'b1, 3'd0);
        check("all_busy_edge_n", bus.busy, 0);
        tick();
        check("all_busy_n1", bus.busy, 1);
        check("all_first_byte", {bus.tx_valid, bus.tx_dc, bus.tx_byte}, {1'b1, 1'b0, 8'h21});
        check("all_first_page", bus.cur_page, 0);
        drain(3000);
        check("all_busy_after", bus.busy, 0);
        repeat (10) tick();
        check("all_quiet", {bus.busy, bus.tx_valid}, 0);

        // single page 3, full-rate ready
        push_page(1'b0, 3);
        strobe(1'b0, 1'b0, 3'd3);
        check("p3_busy_edge_n", bus.busy, 0);
        tick();
        check("p3_busy_n1", bus.busy, 1);
        check("p3_cur_page", bus.cur_page, 3);
        drain(400);
        check("p3_page_time", last_xfer_cyc - mark_cyc, 263);
        check("p3_busy_fall", bus.busy, 0);
        check("p3_cur_page_hold", bus.cur_page, 3);

        // random stalls; rr_ptr=4 after page 3
        stall_mode = 1'b1;
        push_page(1'b0, 1);
        strobe(1'b0, 1'b0, 3'd1);
        n = 0;
        while (exp_q.size() > 124 && n < 500) begin tick(); n++; end
        check("stall_page1_started", bus.cur_page, 1);
        push_page(1'b0, 2);
        push_page(1'b0, 6);
        strobe(1'b0, 1'b0, 3'd6);
        strobe(1'b0, 1'b0, 3'd2);
        drain(5000);
        stall_mode = 1'b0;
        bus.tx_ready = 1'b1;
        repeat (3) tick();
        check("stall_idle", bus.busy, 0);

        // remark page 5 mid-transfer, page 2 marked twice
        push_page(1'b0, 5);
        push_page(1'b0, 2);
        push_page(1'b0, 5);
        strobe(1'b0, 1'b0, 3'd5);
        n = 0;
        while (exp_q.size() > 356 && n < 500) begin tick(); n++; end
        n = 0;
        while (!(bus.tx_valid && bus.tx_dc) && n < 10) begin tick(); n++; end
        check("col40_data", {bus.tx_valid, bus.tx_dc, 5'd0, bus.cur_page}, {1'b1, 1'b1, 5'd0, 3'd5});
        check("col40_byte", bus.tx_byte, fb_pat(10'd680));
        strobe(1'b0, 1'b0, 3'd5);
        strobe(1'b0, 1'b0, 3'd2);
        strobe(1'b0, 1'b0, 3'd2);
        drain(1500);
        repeat (10) tick();
        check("remark_quiet", {bus.busy, bus.tx_valid}, 0);

        // reset during the third command byte
        exp_q.push_back({1'b0, 8'h21});
        exp_q.push_back({1'b0, 8'h00});
        strobe(1'b0, 1'b0, 3'd4);
        tick();
        tick();
        tick();
        check("rst_mid_byte3", {bus.tx_valid, bus.tx_byte}, {1'b1, 8'h7F});
        resetn = 1'b0;
        bus.tx_ready = 1'b0;
        tick();
        check("rst_mid_valid", bus.tx_valid, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_sent", exp_q.size(), 0);
        bus.tx_ready = 1'b1;
`ifdef SCREEN_SCHED_POWERUP_PAINT_EN
        for (int p = 0; p < 8; p++) push_page(1'b0, p);
        for (int p = 0; p < 4; p++) push_page(1'b1, p);
        resetn = 1'b1;
        tick();
        check("paint_start", {bus.tx_valid, bus.tx_byte, 5'd0, bus.cur_page}, {1'b1, 8'h21, 8'd0});
        drain(6000);
`else
        resetn = 1'b1;
        repeat (30) tick();
        check("rst_mid_abandon", {bus.busy, bus.tx_valid}, 0);
`endif

        // COL_START=2, NUM_PAGES=4 instance
        strobe(1'b1, 1'b0, 3'd6);
        repeat (10) tick();
        check("np4_ignore_busy", {bus2.busy, bus2.tx_valid}, 0);
        push_page(1'b1, 3);
        strobe(1'b1, 1'b0, 3'd3);
        tick();
        check("np4_first", {bus2.tx_valid, bus2.tx_byte, 5'd0, bus2.cur_page}, {1'b1, 8'h21, 8'd3});
        drain(400);
        for (int p = 0; p < 4; p++) push_page(1'b1, p);
        strobe(1'b1, 1'b1, 3'd0);
        tick();
        check("np4_wrap_page", bus2.cur_page, 0);
        drain(1500);
        repeat (10) tick();
        check("np4_quiet", {bus2.busy, bus2.tx_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
